// File: rtl/cim_seq_controller_if.sv
// Command handshake bundle between a CIM command issuer and the sequencer.
// The issuer offers cmd/cmd_valid and may cancel with abort; the sequencer answers cmd_ready.
interface cim_seq_controller_if #(
  parameter int CMD_W = 25
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd;
  logic             abort;

  modport master (output cmd_valid, output cmd, output abort, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input abort, output cmd_ready);
endinterface

// File: rtl/cim_seq_controller.sv
// Compute-in-memory sequencer: turns one command into wordline/control patterns.
// Single-cycle ops take one EXEC cycle; MUL walks a 2^len Booth counter. Ready only in IDLE.
module cim_seq_controller #(
  parameter int COL_BITS = 6,
  parameter int MAX_LEN  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cim_seq_controller_if.slave        cmd_if,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [(1<<COL_BITS)-1:0]   rwl_ch1,
  output logic [(1<<COL_BITS)-1:0]   rwl_ch2,
  output logic [(1<<COL_BITS)-1:0]   rwl_ch3,
  output logic [(1<<COL_BITS)-1:0]   wwl_ch1,
  output logic [(1<<COL_BITS)-1:0]   wwl_ch2,
  output logic                       and_en,
  output logic                       xor_en,
  output logic                       mul_en,
  output logic                       booth_sel_h,
  output logic                       booth_sel_l,
  output logic                       booth_wen,
  output logic                       two_data,
  output logic                       neg_data,
  output logic                       shift,
  output logic                       nshift,
  output logic                       special_add
);

  localparam int COL_NUM = 1 << COL_BITS;
  localparam int CMD_W   = 7 + 3 * COL_BITS;

  localparam logic [COL_BITS-1:0] ADDR_ZERO  = '0;
  localparam logic [COL_BITS-1:0] ADDR_BOOTH = COL_BITS'(COL_NUM - 2);
  localparam logic [COL_BITS-1:0] ADDR_SUM   = COL_BITS'(COL_NUM - 1);

  localparam logic [2:0] M_NOP   = 3'b000;
  localparam logic [2:0] M_COPY  = 3'b001;
  localparam logic [2:0] M_AND   = 3'b010;
  localparam logic [2:0] M_XOR   = 3'b011;
  localparam logic [2:0] M_SHIFT = 3'b100;
  localparam logic [2:0] M_ADD   = 3'b101;
  localparam logic [2:0] M_SUB   = 3'b110;
  localparam logic [2:0] M_MUL   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [MAX_LEN-1:0]    cnt_q, cnt_d;
  logic                  special_q, special_d;
  logic [2:0]            mode_q, mode_d;
  logic [2:0]            len_q, len_d;
  logic [COL_BITS-1:0]   rs1_q, rs1_d;
  logic [COL_BITS-1:0]   rs2_q, rs2_d;
  logic [COL_BITS-1:0]   rd_q, rd_d;
  logic                  illegal_q, illegal_d;

  logic [CMD_W-1:0]      cmd_w;
  logic                  in_special;
  logic [2:0]            in_mode;
  logic [2:0]            in_len;
  logic                  in_mul;
  logic                  in_len_ok;

  logic is_copy, is_and, is_xor, is_shift, is_add, is_sub;
  logic sp_add;
  logic mul_last;

  function automatic logic [COL_NUM-1:0] onehot(input logic [COL_BITS-1:0] addr);
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

  assign cmd_w      = cmd_if.cmd;
  assign in_special = cmd_w[CMD_W-1];
  assign in_mode    = cmd_w[CMD_W-2 -: 3];
  assign in_len     = cmd_w[CMD_W-5 -: 3];
  assign in_mul     = (in_mode == M_MUL);
  assign in_len_ok  = (in_len != 3'd0) && (int'(in_len) <= MAX_LEN);

  assign is_copy  = (mode_q == M_COPY);
  assign is_and   = (mode_q == M_AND);
  assign is_xor   = (mode_q == M_XOR);
  assign is_shift = (mode_q == M_SHIFT);
  assign is_add   = (mode_q == M_ADD);
  assign is_sub   = (mode_q == M_SUB);
  assign sp_add   = (is_add | is_sub) & special_q;

  // Final Booth step is cnt == 2^len - 1; len_q is always legal while in ST_MUL.
  assign mul_last = (cnt_q == MAX_LEN'((1 << len_q) - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      special_q <= 1'b0;
      mode_q    <= M_NOP;
      len_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    special_d        = special_q;
    mode_d           = mode_q;
    len_d            = len_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    rd_d             = rd_q;
    illegal_d        = illegal_q;
    cmd_if.cmd_ready = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    err              = 1'b0;
    rwl_ch1          = '0;
    rwl_ch2          = '0;
    rwl_ch3          = '0;
    wwl_ch1          = '0;
    wwl_ch2          = '0;
    and_en           = 1'b0;
    xor_en           = 1'b0;
    mul_en           = 1'b0;
    booth_sel_h      = 1'b0;
    booth_sel_l      = 1'b0;
    booth_wen        = 1'b0;
    two_data         = 1'b0;
    neg_data         = 1'b0;
    shift            = 1'b0;
    nshift           = 1'b0;
    special_add      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_if.cmd_ready = 1'b1;
        if (cmd_if.cmd_valid) begin
          special_d = in_special;
          mode_d    = in_mode;
          len_d     = in_len;
          rs1_d     = cmd_w[3*COL_BITS-1 -: COL_BITS];
          rs2_d     = cmd_w[2*COL_BITS-1 -: COL_BITS];
          rd_d      = cmd_w[COL_BITS-1:0];
          illegal_d = in_mul && !in_len_ok;
          cnt_d     = '0;
          state_d   = (in_mul && in_len_ok) ? ST_MUL : ST_EXEC;
        end
      end

      ST_EXEC: begin
        busy    = 1'b1;
        done    = !cmd_if.abort;
        state_d = ST_IDLE;
        if (illegal_q) begin
          err = 1'b1;
        end else if (mode_q != M_NOP) begin
          and_en      = is_and;
          xor_en      = is_copy | is_xor | is_shift;
          two_data    = is_shift;
          neg_data    = is_sub;
          nshift      = is_add | is_sub;
          special_add = sp_add;
          booth_wen   = 1'b1;
          rwl_ch2     = onehot(rs1_q);
          rwl_ch3     = onehot(rs2_q);
          // Special add works on the odd partner row of rs1/rd.
          if (sp_add) begin
            rwl_ch1 = onehot({rs1_q[COL_BITS-1:1], 1'b1});
            wwl_ch1 = onehot({rd_q[COL_BITS-1:1], 1'b1});
          end else if (is_and | is_xor | is_copy | is_shift) begin
            wwl_ch1 = onehot(rd_q);
          end
          if (is_add | is_sub) begin
            wwl_ch2 = onehot(rd_q);
          end
        end
      end

      ST_MUL: begin
        busy        = 1'b1;
        mul_en      = 1'b1;
        booth_sel_h = special_q;
        booth_sel_l = !special_q;
        shift       = !mul_last;
        nshift      = mul_last;
        done        = mul_last && !cmd_if.abort;
        rwl_ch2     = onehot(rs1_q);
        // Even steps fold rs1 into the Booth/SUM rows; odd steps write back.
        if (!cnt_q[0]) begin
          rwl_ch1 = onehot(rs1_q);
          rwl_ch3 = (cnt_q == '0) ? onehot(ADDR_ZERO) : onehot(rd_q);
          wwl_ch1 = onehot(ADDR_BOOTH);
          wwl_ch2 = onehot(ADDR_SUM);
        end else begin
          rwl_ch1 = onehot(ADDR_BOOTH);
          rwl_ch3 = onehot(ADDR_SUM);
          wwl_ch1 = onehot(rs1_q);
          wwl_ch2 = onehot(rd_q);
        end
        if (cmd_if.abort || mul_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MAX_LEN'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cim_seq_controller.sv
// Scoreboard bench for cim_seq_controller: expected cycle vectors are queued as
// commands are issued, then popped and compared at each falling edge.
module tb_cim_seq_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cim_seq_controller_if #(.CMD_W(25)) if6 ();
  cim_seq_controller_if #(.CMD_W(19)) if4 ();

  logic        busy6, done6, err6, and6, xor6, mul6, bsh6, bsl6, bwen6, two6, neg6, sh6, nsh6, sadd6;
  logic [63:0] r1_6, r2_6, r3_6, w1_6, w2_6;
  logic        busy4, done4, err4, and4, xor4, mul4, bsh4, bsl4, bwen4, two4, neg4, sh4, nsh4, sadd4;
  logic [15:0] r1_4, r2_4, r3_4, w1_4, w2_4;

  cim_seq_controller #(.COL_BITS(6), .MAX_LEN(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_if(if6),
    .busy(busy6), .done(done6), .err(err6),
    .rwl_ch1(r1_6), .rwl_ch2(r2_6), .rwl_ch3(r3_6), .wwl_ch1(w1_6), .wwl_ch2(w2_6),
    .and_en(and6), .xor_en(xor6), .mul_en(mul6), .booth_sel_h(bsh6), .booth_sel_l(bsl6),
    .booth_wen(bwen6), .two_data(two6), .neg_data(neg6), .shift(sh6), .nshift(nsh6),
    .special_add(sadd6)
  );

  cim_seq_controller #(.COL_BITS(4), .MAX_LEN(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_if(if4),
    .busy(busy4), .done(done4), .err(err4),
    .rwl_ch1(r1_4), .rwl_ch2(r2_4), .rwl_ch3(r3_4), .wwl_ch1(w1_4), .wwl_ch2(w2_4),
    .and_en(and4), .xor_en(xor4), .mul_en(mul4), .booth_sel_h(bsh4), .booth_sel_l(bsl4),
    .booth_wen(bwen4), .two_data(two4), .neg_data(neg4), .shift(sh4), .nshift(nsh4),
    .special_add(sadd4)
  );

  typedef struct packed {
    logic [63:0] r1, r2, r3, w1, w2;
    logic [14:0] c;
  } exp_t;

  localparam logic [14:0] C_RDY  = 15'h0001, C_BUSY = 15'h0002, C_DONE = 15'h0004;
  localparam logic [14:0] C_ERR  = 15'h0008, C_AND  = 15'h0010, C_XOR  = 15'h0020;
  localparam logic [14:0] C_MUL  = 15'h0040, C_BSH  = 15'h0080, C_BSL  = 15'h0100;
  localparam logic [14:0] C_BWEN = 15'h0200, C_TWO  = 15'h0400, C_NEG  = 15'h0800;
  localparam logic [14:0] C_SH   = 15'h1000, C_NSH  = 15'h2000, C_SADD = 15'h4000;

  exp_t sb[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [63:0] oh(input int b);
    logic [63:0] v;
    v = '0;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(input int r1, r2, r3, w1, w2, input logic [14:0] c);
    exp_t e;
    e.r1 = oh(r1); e.r2 = oh(r2); e.r3 = oh(r3); e.w1 = oh(w1); e.w2 = oh(w2); e.c = c;
    return e;
  endfunction

  function automatic exp_t smp6();
    exp_t o;
    o.r1 = r1_6; o.r2 = r2_6; o.r3 = r3_6; o.w1 = w1_6; o.w2 = w2_6;
    o.c  = {sadd6, nsh6, sh6, neg6, two6, bwen6, bsl6, bsh6, mul6, xor6, and6,
            err6, done6, busy6, if6.cmd_ready};
    return o;
  endfunction

  function automatic exp_t smp4();
    exp_t o;
    o.r1 = {48'b0, r1_4}; o.r2 = {48'b0, r2_4}; o.r3 = {48'b0, r3_4};
    o.w1 = {48'b0, w1_4}; o.w2 = {48'b0, w2_4};
    o.c  = {sadd4, nsh4, sh4, neg4, two4, bwen4, bsl4, bsh4, mul4, xor4, and4,
            err4, done4, busy4, if4.cmd_ready};
    return o;
  endfunction

  function automatic logic [24:0] pk6(input logic sp, input logic [2:0] md, ln,
                                      input logic [5:0] a, b, d);
    return {sp, md, ln, a, b, d};
  endfunction

  function automatic logic [18:0] pk4(input logic sp, input logic [2:0] md, ln,
                                      input logic [3:0] a, b, d);
    return {sp, md, ln, a, b, d};
  endfunction

  // Offer one command for a single accepting edge, then scramble cmd (don't-care).
  task automatic send6(input logic [24:0] c);
    @(posedge clk); #1;
    if6.cmd_valid = 1'b1; if6.cmd = c;
    @(posedge clk); #1;
    if6.cmd_valid = 1'b0; if6.cmd = 25'($urandom);
  endtask

  task automatic send4(input logic [18:0] c);
    @(posedge clk); #1;
    if4.cmd_valid = 1'b1; if4.cmd = c;
    @(posedge clk); #1;
    if4.cmd_valid = 1'b0; if4.cmd = 19'($urandom);
  endtask

  task automatic test_reset();
    exp_t e, o;
    #2 rst_n = 1'b0;
    if6.cmd_valid = 1'b1; if6.cmd = pk6(1'b0, 3'b010, 3'd0, 6'd1, 6'd2, 6'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = mk(-1, -1, -1, -1, -1, C_RDY);
    o = smp6(); nvec++;
    if (o !== e) begin nbad++; $display("FAIL reset_dut6: got %h exp %h", o, e); end
    o = smp4(); nvec++;
    if (o !== e) begin nbad++; $display("FAIL reset_dut4: got %h exp %h", o, e); end
    rst_n = 1'b1;
    sb.push_back(mk(-1, 1, 2, 3, -1, C_BUSY | C_DONE | C_AND | C_BWEN));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    @(posedge clk); #1 if6.cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL first_accept: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_mul_len1();
    exp_t e, o;
    send6(pk6(1'b0, 3'b111, 3'd1, 6'd5, 6'd20, 6'd9));
    sb.push_back(mk(5, 5, 0, 62, 63, C_BUSY | C_MUL | C_BSL | C_SH));
    sb.push_back(mk(62, 5, 63, 5, 9, C_BUSY | C_MUL | C_BSL | C_NSH | C_DONE));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    repeat (3) begin
      @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL mul_len1: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_add_special();
    exp_t e, o;
    send6(pk6(1'b1, 3'b101, 3'd0, 6'd4, 6'd8, 6'd12));
    sb.push_back(mk(5, 4, 8, 13, 12, C_BUSY | C_DONE | C_NSH | C_SADD | C_BWEN));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    repeat (2) begin
      @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL add_special: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_exec_modes();
    exp_t e, o;
    logic sp;
    logic [2:0] md;
    for (int k = 0; k < 8; k++) begin
      sp = 1'b0;
      case (k)
        0: begin md = 3'b000; e = mk(-1, -1, -1, -1, -1, C_BUSY | C_DONE); end
        1: begin md = 3'b001; e = mk(-1, 6, 7, 10, -1, C_BUSY | C_DONE | C_XOR | C_BWEN); end
        2: begin md = 3'b010; e = mk(-1, 6, 7, 10, -1, C_BUSY | C_DONE | C_AND | C_BWEN); end
        3: begin md = 3'b011; sp = 1'b1; e = mk(-1, 6, 7, 10, -1, C_BUSY | C_DONE | C_XOR | C_BWEN); end
        4: begin md = 3'b100; e = mk(-1, 6, 7, 10, -1, C_BUSY | C_DONE | C_XOR | C_TWO | C_BWEN); end
        5: begin md = 3'b101; e = mk(-1, 6, 7, -1, 10, C_BUSY | C_DONE | C_NSH | C_BWEN); end
        6: begin md = 3'b110; sp = 1'b1;
                  e = mk(7, 6, 7, 11, 10, C_BUSY | C_DONE | C_NEG | C_NSH | C_SADD | C_BWEN); end
        default: begin md = 3'b110; e = mk(-1, 6, 7, -1, 10, C_BUSY | C_DONE | C_NEG | C_NSH | C_BWEN); end
      endcase
      send6(pk6(sp, md, 3'd2, 6'd6, 6'd7, 6'd10));
      sb.push_back(e);
      sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
      repeat (2) begin
        @(negedge clk);
        e = sb.pop_front(); o = smp6(); nvec++;
        if (o !== e) begin nbad++; $display("FAIL exec_mode%0d: got %h exp %h", md, o, e); end
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e, o;
    logic [2:0] lens [3] = '{3'd6, 3'd7, 3'd0};
    foreach (lens[k]) begin
      send6(pk6(1'b0, 3'b111, lens[k], 6'd3, 6'd4, 6'd5));
      sb.push_back(mk(-1, -1, -1, -1, -1, C_BUSY | C_DONE | C_ERR));
      sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
      repeat (2) begin
        @(negedge clk);
        e = sb.pop_front(); o = smp6(); nvec++;
        if (o !== e) begin nbad++; $display("FAIL illegal_len%0d: got %h exp %h", lens[k], o, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    @(posedge clk); #1;
    if6.cmd_valid = 1'b1; if6.cmd = pk6(1'b1, 3'b111, 3'd5, 6'd2, 6'd0, 6'd7);
    @(posedge clk); #1;
    if6.cmd = pk6(1'b0, 3'b010, 3'd0, 6'd1, 6'd2, 6'd3);
    for (int c = 0; c < 32; c++) begin
      if (c[0] == 1'b0)
        e = mk(2, 2, (c == 0) ? 0 : 7, 62, 63, C_BUSY | C_MUL | C_BSH);
      else
        e = mk(62, 2, 63, 2, 7, C_BUSY | C_MUL | C_BSH);
      e.c |= (c < 31) ? C_SH : (C_NSH | C_DONE);
      sb.push_back(e);
    end
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    repeat (33) begin
      @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL mul_len5: got %h exp %h", o, e); end
    end
    @(posedge clk); #1 if6.cmd_valid = 1'b0;
    sb.push_back(mk(-1, 1, 2, 3, -1, C_BUSY | C_DONE | C_AND | C_BWEN));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    repeat (2) begin
      @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL held_second_cmd: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_abort();
    exp_t e, o;
    send6(pk6(1'b0, 3'b111, 3'd3, 6'd1, 6'd0, 6'd3));
    sb.push_back(mk(1, 1, 0, 62, 63, C_BUSY | C_MUL | C_BSL | C_SH));
    sb.push_back(mk(62, 1, 63, 1, 3, C_BUSY | C_MUL | C_BSL | C_SH));
    sb.push_back(mk(1, 1, 3, 62, 63, C_BUSY | C_MUL | C_BSL | C_SH));
    sb.push_back(mk(62, 1, 63, 1, 3, C_BUSY | C_MUL | C_BSL | C_SH));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin @(posedge clk); #1 if6.abort = 1'b1; end
      if (i == 4) begin @(posedge clk); #1 if6.abort = 1'b0; end
      @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL abort_step%0d: got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e, o;
    send6(pk6(1'b1, 3'b111, 3'd3, 6'd4, 6'd0, 6'd5));
    sb.push_back(mk(4, 4, 0, 62, 63, C_BUSY | C_MUL | C_BSH | C_SH));
    sb.push_back(mk(62, 4, 63, 4, 5, C_BUSY | C_MUL | C_BSH | C_SH));
    sb.push_back(mk(4, 4, 5, 62, 63, C_BUSY | C_MUL | C_BSH | C_SH));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin #2 rst_n = 1'b0; #1; end
      else @(negedge clk);
      e = sb.pop_front(); o = smp6(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL reset_mid_mul%0d: got %h exp %h", i, o, e); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_col4();
    exp_t e, o;
    send4(pk4(1'b0, 3'b111, 3'd1, 4'd5, 4'd0, 4'd9));
    sb.push_back(mk(5, 5, 0, 14, 15, C_BUSY | C_MUL | C_BSL | C_SH));
    sb.push_back(mk(14, 5, 15, 5, 9, C_BUSY | C_MUL | C_BSL | C_NSH | C_DONE));
    sb.push_back(mk(-1, -1, -1, -1, -1, C_RDY));
    repeat (3) begin
      @(negedge clk);
      e = sb.pop_front(); o = smp4(); nvec++;
      if (o !== e) begin nbad++; $display("FAIL col4_mul: got %h exp %h", o, e); end
    end
  endtask

  initial begin
    if6.cmd_valid = 1'b0; if6.cmd = '0; if6.abort = 1'b0;
    if4.cmd_valid = 1'b0; if4.cmd = '0; if4.abort = 1'b0;
    test_reset();
    test_mul_len1();
    test_add_special();
    test_exec_modes();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_reset_mid_mul();
    test_col4();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cim_seq_controller.md
CIM_SEQ_CONTROLLER -- requirements
Module: cim_seq_controller

Interface
REQ-001 Parameter COL_BITS, default 6, SRAM column address width; COL_NUM = 2^COL_BITS wordlines.
REQ-002 Parameter MAX_LEN, default 5, largest legal MUL length code; counter width MAX_LEN.
REQ-003 Parameter CMD_W = 7 + 3*COL_BITS, derived, not overridden.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 cmd  input  CMD_W  {special[1], mode[3], len[3], rs1, rs2, rd} (MSB first; each address COL_BITS wide).
REQ-009 abort  input  1  synchronous cancel of the current command.
REQ-010 busy  output  1  state != IDLE.
REQ-011 done  output  1  one-cycle pulse in the final execute cycle of a command.
REQ-012 err  output  1  one-cycle pulse, illegal command.
REQ-013 rwl_ch1, rwl_ch2, rwl_ch3  output  COL_NUM each  one-hot read wordlines.
REQ-014 wwl_ch1, wwl_ch2  output  COL_NUM each  one-hot write wordlines.
REQ-015 and_en, xor_en, mul_en, booth_sel_h, booth_sel_l, booth_wen, two_data, neg_data, shift, nshift, special_add  output  1 each  compute-array controls.

Function
REQ-016 Modes: 000 NOP, 001 COPY, 010 AND, 011 XOR, 100 SHIFT, 101 ADD, 110 SUB, 111 MUL.
REQ-017 States IDLE, EXEC, MUL; cmd_ready = (state==IDLE); the command is registered on acceptance and held internally, so cmd is don't-care afterwards.
REQ-018 Accept in IDLE at edge t: non-MUL goes to EXEC for exactly cycle t+1, with done=1; back to IDLE at t+2.
REQ-019 NOP: EXEC cycle with done=1; all wordlines and controls 0.
REQ-020 EXEC decode: and_en=AND; xor_en=COPY|XOR|SHIFT; two_data=SHIFT; neg_data=SUB; nshift=ADD|SUB; special_add=(ADD|SUB)&special; booth_wen=1; mul_en, shift, booth_sel_* = 0.
REQ-021 EXEC wordlines: rwl_ch2=onehot(rs1); rwl_ch3=onehot(rs2); rwl_ch1=onehot({rs1[msb:1],1}) only if special_add; wwl_ch1=onehot(rd) for AND/XOR/COPY/SHIFT; wwl_ch1=onehot({rd[msb:1],1}) if special_add; wwl_ch2=onehot(rd) for ADD/SUB; else 0.
REQ-022 MUL with len in 1..MAX_LEN: counter cnt runs 0..N-1, N=2^len, one cycle per value; exit to IDLE after cnt=N-1, which carries done=1.
REQ-023 MUL controls every cycle: mul_en=1, booth_wen=0, booth_sel_h=special, booth_sel_l=~special; shift=1 for cnt<N-1; nshift=1 only at cnt=N-1.
REQ-024 Special addresses: ZERO=0, BOOTH=COL_NUM-2, SUM=COL_NUM-1.
REQ-025 MUL even cnt: rwl_ch1=rs1, wwl_ch1=BOOTH, wwl_ch2=SUM; rwl_ch3=ZERO at cnt=0, else rd. Odd cnt: rwl_ch1=BOOTH, wwl_ch1=rs1, rwl_ch3=SUM, wwl_ch2=rd. rwl_ch2=rs1 always.
REQ-026 Illegal: MUL with len=0 or len>MAX_LEN -> single EXEC cycle with err=1, done=1, all wordlines/controls 0.
REQ-027 Wordline outputs are one-hot or all-zero in every cycle; never multi-hot.
REQ-028 abort high in EXEC/MUL: next state IDLE, no done, cnt cleared; outputs in that cycle follow the current state; abort in IDLE ignored.
REQ-029 In IDLE all wordlines and controls are 0, busy=0.

Reset
REQ-030 rst_n low asynchronously forces IDLE, cnt=0, and the command register cleared; all outputs 0 except cmd_ready=1, including mid-MUL.
REQ-031 First acceptance is possible on the first rising edge with rst_n high.

Verification
REQ-032 MUL, len=1, rs1=5, rd=9, special=0 -> 2 cycles: cnt0 rwl_ch1 bit5, rwl_ch3 bit0, wwl_ch1 bit62, wwl_ch2 bit63, shift=1; cnt1 rwl_ch1 bit62, rwl_ch3 bit63, wwl_ch1 bit5, wwl_ch2 bit9, nshift=1, done=1.
REQ-033 ADD special, rs1=4, rs2=8, rd=12 -> one EXEC cycle: rwl_ch1 bit5, rwl_ch2 bit4, rwl_ch3 bit8, wwl_ch1 bit13, wwl_ch2 bit12, special_add=1, done=1.
REQ-034 MUL len=5 -> busy for 32 cycles, cmd_ready=0 throughout; a second command held valid is accepted on the edge after done.
REQ-035 MUL len=6 with MAX_LEN=5 -> err=1, done=1 for one cycle, no wordline asserted.
REQ-036 abort at cnt=3 of a len=3 MUL -> IDLE next cycle, no done; rst_n pulled low at cnt=2 of another MUL -> outputs 0 immediately, cmd_ready=1.
REQ-037 Rerun REQ-032 with COL_BITS=4 -> BOOTH=bit14, SUM=bit15.
